// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: read-only ID word at index 0, byte-writable control words above it.
// Independent write (AW/W/B) and read (AR/R) engines, one transaction of each kind in flight.
module axi_lite_reg_slave #(
   parameter int unsigned N_REGS    = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] ID_VALUE  = 32'h5349_5443
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            s_axi_awaddr,
   input  logic [2:0]             s_axi_awprot,
   input  logic                   s_axi_awvalid,
   output logic                   s_axi_awready,
   input  logic [31:0]            s_axi_wdata,
   input  logic [3:0]             s_axi_wstrb,
   input  logic                   s_axi_wvalid,
   output logic                   s_axi_wready,
   output logic [1:0]             s_axi_bresp,
   output logic                   s_axi_bvalid,
   input  logic                   s_axi_bready,
   input  logic [31:0]            s_axi_araddr,
   input  logic [2:0]             s_axi_arprot,
   input  logic                   s_axi_arvalid,
   output logic                   s_axi_arready,
   output logic [31:0]            s_axi_rdata,
   output logic [1:0]             s_axi_rresp,
   output logic                   s_axi_rvalid,
   input  logic                   s_axi_rready,
   output logic [32*N_REGS-1:0]   reg_out,
   output logic [N_REGS-1:0]      wr_pulse
);

   localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_RESP} rstate_t;

   wstate_t           wstate, wstate_nxt;
   rstate_t           rstate, rstate_nxt;
   logic              aw_got, w_got;
   logic              aw_hs, w_hs, ar_hs;
   logic [31:0]       awaddr_q, wdata_q;
   logic [3:0]        wstrb_q;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [1:0]        wr_resp;
   logic [31:0]       rw_q [1:N_REGS-1];
   logic              unused_prot;

   function automatic logic addr_hit(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      return (addr >= BASE_ADDR) && (off < 32'(4 * N_REGS));
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      return off[IDX_W+1:2];
   endfunction

   assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   // Write engine: state register
   always_ff @(posedge clk) begin
      if (rst) wstate <= W_IDLE;
      else     wstate <= wstate_nxt;
   end

   // Write engine: next state
   always_comb begin
      wstate_nxt = wstate;
      case (wstate)
         W_IDLE:   if ((aw_got || aw_hs) && (w_got || w_hs)) wstate_nxt = W_COMMIT;
         W_COMMIT: wstate_nxt = W_RESP;
         W_RESP:   if (s_axi_bready) wstate_nxt = W_IDLE;
         default:  wstate_nxt = W_IDLE;
      endcase
   end

   // Write engine: outputs (all quiet while in reset)
   always_comb begin
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      if (!rst) begin
         case (wstate)
            W_IDLE: begin
               s_axi_awready = !aw_got;
               s_axi_wready  = !w_got;
            end
            W_RESP:  s_axi_bvalid = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_got <= 1'b0;
         w_got  <= 1'b0;
      end else if (wstate == W_COMMIT) begin
         aw_got <= 1'b0;
         w_got  <= 1'b0;
      end else begin
         if (aw_hs) aw_got <= 1'b1;
         if (w_hs)  w_got  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
         wdata_q <= s_axi_wdata;
         wstrb_q <= s_axi_wstrb;
      end
   end

   assign wr_idx = addr_idx(awaddr_q);

   always_comb begin
      wr_resp = RESP_OKAY;
      if (!addr_hit(awaddr_q))       wr_resp = RESP_DECERR;
      else if (wr_idx == '0)         wr_resp = RESP_SLVERR;
   end

   // Commit stage: byte-lane update of the addressed RW word
   always_ff @(posedge clk) begin
      for (int i = 1; i < N_REGS; i++) begin
         if (rst) begin
            rw_q[i] <= '0;
         end else if (wstate == W_COMMIT && wr_resp == RESP_OKAY && wr_idx == IDX_W'(i)) begin
            for (int b = 0; b < 4; b++)
               if (wstrb_q[b]) rw_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_axi_bresp <= RESP_OKAY;
         wr_pulse    <= '0;
      end else begin
         wr_pulse <= '0;
         if (wstate == W_COMMIT) begin
            s_axi_bresp <= wr_resp;
            if (wr_resp == RESP_OKAY) wr_pulse[wr_idx] <= 1'b1;
         end
      end
   end

   assign reg_out[31:0] = ID_VALUE;
   for (genvar g = 1; g < N_REGS; g++) begin : g_out
      assign reg_out[32*g +: 32] = rw_q[g];
   end

   // Read engine: state register
   always_ff @(posedge clk) begin
      if (rst) rstate <= R_IDLE;
      else     rstate <= rstate_nxt;
   end

   // Read engine: next state
   always_comb begin
      rstate_nxt = rstate;
      case (rstate)
         R_IDLE:  if (ar_hs) rstate_nxt = R_RESP;
         R_RESP:  if (s_axi_rready) rstate_nxt = R_IDLE;
         default: rstate_nxt = R_IDLE;
      endcase
   end

   // Read engine: outputs
   always_comb begin
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      if (!rst) begin
         s_axi_arready = (rstate == R_IDLE);
         s_axi_rvalid  = (rstate == R_RESP);
      end
   end

   assign rd_idx = addr_idx(s_axi_araddr);

   // Sampled from the pre-edge register state, so a coincident commit is not visible
   always_ff @(posedge clk) begin
      if (rst) begin
         s_axi_rdata <= '0;
         s_axi_rresp <= RESP_OKAY;
      end else if (ar_hs) begin
         if (addr_hit(s_axi_araddr)) begin
            s_axi_rdata <= reg_out[32*rd_idx +: 32];
            s_axi_rresp <= RESP_OKAY;
         end else begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_DECERR;
         end
      end
   end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI4-Lite slave register bank that terminates the AXI master side of the SiTCP RBCP bridge. It decodes byte-lane writes (one-hot wstrb, replicated wdata) and word reads into a file of 32-bit control registers. Register 0 is a read-only ID word. Registers 1..N_REGS-1 are read/write and drive fabric control logic. AW, W, B, AR and R channels are all handled independently, with full VALID/READY compliance.

Parameters:
N_REGS, 16, number of 32-bit registers (2..256); register 0 is the ID register.
BASE_ADDR, 32'h0000_0000, byte address of register 0; must be aligned to 4*N_REGS rounded up to a power of two.
ID_VALUE, 32'h5349_5443, constant value returned by register 0.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_axi_awaddr  in  32  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte lane enables, little endian
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  32  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
reg_out  out  32*N_REGS  flattened register contents; register i occupies bits [32i+31:32i]; slice 0 = ID_VALUE
wr_pulse  out  N_REGS  one-cycle strobe per register on a successful write

Behaviour:
- Reset (synchronous, rst=1): all RW registers = 0. awready, wready, arready, bvalid, rvalid, wr_pulse = 0. bresp, rresp, rdata = 0. FSMs go to IDLE. Any in-flight transaction is dropped with no response.
- Ready signals are 0 during reset and assert the cycle after rst deasserts.
- Address decode: off = addr - BASE_ADDR. In range iff addr >= BASE_ADDR and off < 4*N_REGS. idx = off[..:2]. addr[1:0] is ignored; the byte lane is selected by wstrb only.
- Write FSM states: W_IDLE, W_COMMIT, W_RESP.
  - W_IDLE: awready = !aw_got; wready = !w_got. An AW handshake latches awaddr and sets aw_got; a W handshake latches wdata/wstrb and sets w_got. AW and W may arrive in either order or in the same cycle.
  - W_IDLE -> W_COMMIT at the clock edge where both are held or handshaking.
  - W_COMMIT (1 cycle, all readies 0): for in range with idx != 0, byte k is updated iff wstrb[k]=1; bresp = OKAY (00). For idx = 0, no update and bresp = SLVERR (10). Out of range: no update, bresp = DECERR (11). Clear aw_got/w_got, then go to W_RESP.
  - W_RESP: bvalid = 1, bresp held stable until the bvalid & bready edge, then return to W_IDLE.
  - Latency: last AW/W handshake in cycle T -> register value and bvalid visible in cycle T+2. Minimum back-to-back write interval is 3 cycles when bready is tied high.
- wr_pulse[idx] is high for exactly the first bvalid cycle, and only on OKAY. wstrb=0000 with an in-range RW address still gives OKAY and a pulse, with no data change.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: arready = 1. An AR handshake in cycle T latches rdata and rresp from the register state at T, and rvalid asserts in T+1.
  - In range: rdata = register word (ID_VALUE for idx 0) and rresp = OKAY. Out of range: rdata = 0 and rresp = DECERR.
  - R_RESP: arready = 0. rvalid, rdata and rresp are held until the rvalid & rready edge, then return to R_IDLE.
- Read and write FSMs are independent. A read handshaking in the same cycle as a W_COMMIT to the same register returns the pre-write value.
- No outstanding-transaction queue: at most one write and one read in flight.
- s_axi_awprot and s_axi_arprot have no effect.

Test Plan:
- Byte-lane write: write reg 2 with wdata=32'hABAB_ABAB, wstrb=4'b0100, bready=1 -> reg_out[95:64]=32'h00AB_0000; bresp=00; wr_pulse[2] high for 1 cycle; bvalid 2 cycles after the last handshake.
- Four sequential byte writes of 11/22/33/44 to addresses 0x0C..0x0F (wstrb walks 0001..1000), then read 0x0C -> rdata=32'h4433_2211, rresp=00, rvalid 1 cycle after AR.
- W presented 5 cycles before AW; then AW and W in the same cycle -> both complete with OKAY. bready held 0 for 4 cycles -> bvalid/bresp stable, awready=0 until B accepted.
- Write to 0x00 -> bresp=10, reg 0 still reads 32'h5349_5443. Write/read at 0x40 with N_REGS=16 -> bresp=11, rresp=11, rdata=0, no wr_pulse.
- Read of reg 3 handshaking in the W_COMMIT cycle of a write 0xFF to reg 3 (old value 0) -> rdata=0; a following read returns 32'h0000_00FF. rready held 0 for 3 cycles -> rvalid/rdata stable.
- rst asserted while bvalid=1 and rvalid=1 -> both 0 next cycle; RW registers=0; after release a new write completes normally.
